// File: rtl/vp_pkg.sv
// Shared vector-processor constants: result widths, lane geometry and source tags.
// Also holds the readback FSM state type so the bench and RTL agree on it.
`timescale 1ns/1ps
package vp_pkg;

  localparam int VEC_W  = 512;
  localparam int LANE_W = 32;
  localparam int NLANES = VEC_W / LANE_W;
  localparam int TAG_W  = 2;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = $clog2(NLANES);

  localparam logic [TAG_W-1:0] TAG_REG = 2'd0;
  localparam logic [TAG_W-1:0] TAG_A3  = 2'd1;
  localparam logic [TAG_W-1:0] TAG_A4  = 2'd2;
  localparam logic [TAG_W-1:0] TAG_MEM = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/vec_result_readback.sv
// Captures one wide result vector plus tag and streams it out lane 0 first
// as LANE_W-bit beats over a valid/ready interface.
`timescale 1ns/1ps
module vec_result_readback
  import vp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [VEC_W-1:0]  vec_in,
  input  logic [TAG_W-1:0]  vec_tag,
  input  logic              vec_valid,
  output logic              vec_ready,
  output logic [LANE_W-1:0] lane_data,
  output logic [IDX_W-1:0]  lane_idx,
  output logic [TAG_W-1:0]  lane_tag,
  output logic              lane_last,
  output logic              lane_valid,
  input  logic              lane_ready,
  output logic [CNT_W-1:0]  vec_count,
  output logic              busy
);

  // Handshakes: a beat moves on a rising edge where valid and ready are both
  // high; valid never depends on ready, and held outputs stay stable while stalled.

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   buf_q, buf_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lane_fire;
  logic               last_fire;
  logic               capture;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    lane_fire = (state_q == ST_SEND) && lane_ready;
    last_fire = lane_fire && (idx_q == IDX_W'(NLANES - 1));
    vec_ready = (state_q == ST_IDLE) || last_fire;
    capture   = vec_valid && vec_ready;

    // The buffer shifts down so the current lane always sits in the low bits.
    if (lane_fire) begin
      buf_d = buf_q >> LANE_W;
      idx_d = idx_q + IDX_W'(1);
    end
    if (last_fire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = '0;
      state_d = ST_IDLE;
    end
    // A capture on the last-lane edge overrides the return to idle.
    if (capture) begin
      buf_d   = vec_in;
      tag_d   = vec_tag;
      idx_d   = '0;
      state_d = ST_SEND;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lane_valid = (state_q == ST_SEND);
  assign busy       = (state_q == ST_SEND);
  assign lane_data  = buf_q[LANE_W-1:0];
  assign lane_idx   = idx_q;
  assign lane_tag   = tag_q;
  assign lane_last  = lane_valid && (idx_q == IDX_W'(NLANES - 1));
  assign vec_count  = cnt_q;

endmodule
